count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Control FSM that sequences the team's 4-bit synchronous up counter. It starts, pauses, resumes and terminates counting against a limit latched at start. One-shot and auto-reload modes are supported. The block reports run status, a one-cycle completion pulse and a reload tally to the surrounding lab-top logic.

Parameters:
WIDTH, 4, counter width in bits
TALLY_W, 4, width of the auto-reload wrap tally

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  level, sampled each cycle; begins a run in IDLE, resumes in HOLD
stop  input  1  level, sampled each cycle; pauses in RUN, aborts in HOLD
mode  input  1  0 = one-shot, 1 = auto-reload; latched with limit at start from IDLE
limit  input  WIDTH  terminal count value; latched at start from IDLE
count  output  WIDTH  current counter value
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse on reaching limit
tally  output  TALLY_W  number of auto-reload wraps since last start from IDLE

Behaviour:
- Reset: reset==0 at a rising edge forces the following, regardless of state or inputs:
  - state=IDLE; count=0; busy=0; done=0; tally=0
  - latched limit=0; latched mode=0
  - Reset mid-run aborts the run silently, with no done pulse.
- All outputs are registered. There is no combinational path from input to output.
- States are IDLE, RUN, HOLD and DONE. busy=1 exactly in RUN and HOLD.
- IDLE:
  - start=1 and stop=0: latch limit and mode, count<=0, tally<=0, go to RUN.
  - Otherwise hold. count retains its last value.
- RUN, evaluated in this priority order:
  - stop=1: go to HOLD, count frozen. This holds even if count==limit, in which case no done pulse is produced.
  - count==latched limit and mode=0: go to DONE, done<=1, count holds at limit.
  - count==latched limit and mode=1: stay in RUN, count<=0, done<=1, tally<=tally+1 (wraps modulo 2^TALLY_W).
  - Otherwise: count<=count+1.
- HOLD:
  - stop=1: go to IDLE, count<=0. stop has priority over start.
  - start=1 and stop=0: go to RUN, resuming from the frozen count.
  - Otherwise hold. The latched limit and mode are unchanged.
- DONE: go to IDLE unconditionally after one cycle. done<=0. count stays at limit until the next start.
- done is high for exactly one cycle per limit hit.
- Latency, with start sampled at edge N:
  - count=0 after edge N+1; count=k after edge N+1+k.
  - count==L after edge N+1+L.
  - done=1 after edge N+2+L.
- limit=0:
  - one-shot: done pulses 2 cycles after start.
  - auto-reload: done pulses every cycle; count stays 0; tally increments each cycle.
- Simultaneous start and stop: stop wins in every state. In IDLE both high means no action.
- start held high is level-sensitive:
  - In IDLE, a new run begins one cycle after DONE returns to IDLE.
  - In RUN, start has no effect.
- Changes to limit or mode during RUN or HOLD are ignored.
- Counter arithmetic is unsigned modulo 2^WIDTH. Because count never exceeds the latched limit, no overflow is reachable.

Decomposition:
- Shared package: state enum (IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11) and default WIDTH/TALLY_W constants.
- Natural sub-module: up_counter. It is a WIDTH-bit synchronous counter with inputs clk, reset (active-low, synchronous), en and clr, and output q.
- count_sequencer drives en and clr from its FSM and compares q against the latched limit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> count=0, busy=0, done=0, tally=0, state IDLE; on release with start=0 nothing moves.
- One-shot: mode=0, limit=5, start pulsed at edge N -> count steps 0..5 at edges N+1..N+6; done=1 only after edge N+7; busy drops with done; count holds 5.
- Auto-reload: mode=1, limit=3, start pulse then run 12 cycles -> count sequence 0,1,2,3,0,1,2,3,0,...; done pulses every 4th cycle; tally=3 after third wrap; limit changed to 9 mid-run is ignored.
- Pause and abort, limit=7:
  - stop at count=4 -> count frozen 3 cycles, busy=1, no done.
  - start -> resumes 5,6,7, then done.
  - Repeat; stop in HOLD -> IDLE, count=0, no done.
- Edge cases:
  - limit=0 one-shot -> done 2 cycles after start.
  - start and stop both high in IDLE -> no action.
  - stop asserted exactly when count==limit -> HOLD, no done.
- Reset mid-run: assert reset=0 at count=2 in auto-reload -> next cycle all outputs zero, no done pulse; tally restarts at 0.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// ============================================================================
//  count_sequencer_pkg
//  Shared state encoding and default widths for the count sequencer block.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package count_sequencer_pkg;

   localparam int unsigned c_WIDTH_DEFAULT   = 4;
   localparam int unsigned c_TALLY_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/count_sequencer_up_counter.sv
// ============================================================================
//  up_counter
//  WIDTH-bit synchronous up counter; clr has priority over en.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module up_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = q_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/count_sequencer.sv
// ============================================================================
//  count_sequencer
//  Start/pause/resume/abort FSM driving an up_counter against a latched limit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH   = c_WIDTH_DEFAULT,
   parameter int unsigned TALLY_W = c_TALLY_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [WIDTH-1:0]   limit,
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               done,
   output logic [TALLY_W-1:0] tally
);

   state_t               state_q;
   state_t               state_d;
   logic [WIDTH-1:0]     limit_q;
   logic [WIDTH-1:0]     limit_d;
   logic                 mode_q;
   logic                 mode_d;
   logic                 prime_q;
   logic                 prime_d;
   logic                 busy_q;
   logic                 busy_d;
   logic                 done_q;
   logic                 done_d;
   logic [TALLY_W-1:0]   tally_q;
   logic [TALLY_W-1:0]   tally_d;

   logic                 w_cnt_en;
   logic                 w_cnt_clr;
   logic [WIDTH-1:0]     w_cnt;
   logic                 w_go;
   logic                 w_at_limit;

   assign w_go       = start & ~stop;
   assign w_at_limit = (w_cnt == limit_q);

   up_counter #(
      .WIDTH (WIDTH)
   ) u_up_counter (
      .clk   (clk),
      .reset (reset),
      .en    (w_cnt_en),
      .clr   (w_cnt_clr),
      .q     (w_cnt)
   );

   // State register plus all registered outputs and latched run parameters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         limit_q <= '0;
         mode_q  <= 1'b0;
         prime_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tally_q <= '0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         mode_q  <= mode_d;
         prime_q <= prime_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tally_q <= tally_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_go) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_HOLD;
            end else if (!prime_q && w_at_limit && !mode_q) begin
               state_d = ST_DONE;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The first RUN cycle after a start only primes; it survives a pause so a
   // resumed run still spends that cycle at zero before comparing.
   always_comb begin
      w_cnt_en  = 1'b0;
      w_cnt_clr = 1'b0;
      limit_d   = limit_q;
      mode_d    = mode_q;
      prime_d   = prime_q;
      done_d    = 1'b0;
      tally_d   = tally_q;
      case (state_q)
         ST_IDLE: begin
            if (w_go) begin
               limit_d   = limit;
               mode_d    = mode;
               prime_d   = 1'b1;
               tally_d   = '0;
               w_cnt_clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (!stop) begin
               if (prime_q) begin
                  prime_d = 1'b0;
               end else if (w_at_limit) begin
                  done_d = 1'b1;
                  if (mode_q) begin
                     w_cnt_clr = 1'b1;
                     tally_d   = tally_q + TALLY_W'(1);
                  end
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (stop) begin
               w_cnt_clr = 1'b1;
            end
         end
         default: begin
         end
      endcase
      busy_d = is_busy(state_d);
   end

   assign count = w_cnt;
   assign busy  = busy_q;
   assign done  = done_q;
   assign tally = tally_q;

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// ============================================================================
//  tb_count_sequencer
//  Vector table, directed corner sequences and a random run against a model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] limit = 4'd0;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic [3:0] tally;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   count_sequencer #(
      .WIDTH   (4),
      .TALLY_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .limit (limit),
      .count (count),
      .busy  (busy),
      .done  (done),
      .tally (tally)
   );

   // Reference model: progress is counted in run cycles since start, and the
   // visible count/tally/done are derived arithmetically from it.
   int m_prog;
   int m_lim;
   bit m_mode;
   bit m_act;
   bit m_pause;
   bit m_fin;
   int m_cnt;
   int m_tally;
   bit m_done;

   task automatic model_step(input bit r, input bit s, input bit p, input bit m, input int l);
      m_done = 1'b0;
      if (!r) begin
         m_act = 0; m_pause = 0; m_fin = 0; m_lim = 0; m_mode = 0;
         m_cnt = 0; m_tally = 0; m_prog = 0;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (!m_act) begin
         if (s && !p) begin
            m_lim = l; m_mode = m; m_prog = 0; m_act = 1; m_pause = 0;
            m_cnt = 0; m_tally = 0;
         end
      end else if (m_pause) begin
         if (p) begin
            m_act = 0; m_pause = 0; m_cnt = 0;
         end else if (s) begin
            m_pause = 0;
         end
      end else if (p) begin
         m_pause = 1;
      end else begin
         m_prog++;
         if (m_mode) begin
            m_cnt   = (m_prog - 1) % (m_lim + 1);
            m_tally = ((m_prog - 1) / (m_lim + 1)) % 16;
            m_done  = (m_prog >= 2) && (m_cnt == 0);
         end else if (m_prog == m_lim + 2) begin
            m_done = 1; m_act = 0; m_fin = 1; m_cnt = m_lim;
         end else begin
            m_cnt = m_prog - 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit s, input bit p, input bit m, input int l);
      reset = r; start = s; stop = p; mode = m; limit = 4'(l);
      @(posedge clk);
      model_step(r, s, p, m, l);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic e4(input string tag, input int c, input bit b, input bit d, input int t);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".done"},  32'(done),  32'(d));
      chk({tag, ".tally"}, 32'(tally), 32'(t));
   endtask

   typedef struct {
      bit r; bit s; bit p; bit m; int l;
      int ec; bit eb; bit ed; int et;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit s, input bit p, input bit m, input int l,
                      input int ec, input bit eb, input bit ed, input int et);
      vec_t v;
      v.r = r; v.s = s; v.p = p; v.m = m; v.l = l;
      v.ec = ec; v.eb = eb; v.ed = ed; v.et = et;
      vecs.push_back(v);
   endtask

   initial begin
      // reset held with start high, then released idle
      add(0,1,0,0,0, 0,0,0,0); add(0,1,0,0,0, 0,0,0,0); add(0,1,0,0,0, 0,0,0,0);
      add(1,0,0,0,0, 0,0,0,0);
      // one-shot limit 5, limit/mode changes mid-run ignored
      add(1,1,0,0,5, 0,1,0,0); add(1,0,0,1,9, 0,1,0,0);
      for (int k = 1; k <= 5; k++) add(1,0,0,1,9, k,1,0,0);
      add(1,0,0,0,0, 5,0,1,0); add(1,0,0,0,0, 5,0,0,0); add(1,0,0,0,0, 5,0,0,0);
      // auto-reload limit 3, start held in RUN has no effect
      add(1,1,0,1,3, 0,1,0,0); add(1,0,0,0,9, 0,1,0,0);
      add(1,0,0,0,9, 1,1,0,0); add(1,0,0,0,9, 2,1,0,0); add(1,0,0,0,9, 3,1,0,0);
      add(1,0,0,0,9, 0,1,1,1); add(1,1,0,0,9, 1,1,0,1); add(1,0,0,0,9, 2,1,0,1);
      add(1,0,0,0,9, 3,1,0,1); add(1,0,0,0,9, 0,1,1,2); add(1,0,0,0,9, 1,1,0,2);
      add(1,0,0,0,9, 2,1,0,2); add(1,0,0,0,9, 3,1,0,2); add(1,0,0,0,9, 0,1,1,3);
      // pause then abort; both high in IDLE does nothing
      add(1,0,1,0,9, 0,1,0,3); add(1,0,1,0,9, 0,0,0,3);
      add(1,1,1,1,4, 0,0,0,3); add(1,0,0,0,0, 0,0,0,3);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].l);
         e4($sformatf("vec%0d", i), vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].et);
      end

      // pause at 4, frozen, resume to done
      step(1,1,0,0,7); e4("pz_start", 0,1,0,0);
      for (int k = 0; k <= 4; k++) begin step(1,0,0,0,0); e4("pz_run", k,1,0,0); end
      step(1,0,1,0,0); e4("pz_stop", 4,1,0,0);
      for (int k = 0; k < 3; k++) begin step(1,0,0,0,0); e4("pz_hold", 4,1,0,0); end
      step(1,1,0,0,0); e4("pz_resume", 4,1,0,0);
      for (int k = 5; k <= 7; k++) begin step(1,0,0,0,0); e4("pz_run2", k,1,0,0); end
      step(1,0,0,0,0); e4("pz_done", 7,0,1,0);
      step(1,0,0,0,0); e4("pz_idle", 7,0,0,0);
      // abort from HOLD
      step(1,1,0,0,7); e4("ab_start", 0,1,0,0);
      for (int k = 0; k <= 2; k++) begin step(1,0,0,0,0); e4("ab_run", k,1,0,0); end
      step(1,0,1,0,0); e4("ab_hold", 2,1,0,0);
      step(1,0,1,0,0); e4("ab_abort", 0,0,0,0);
      step(1,0,0,0,0); e4("ab_idle", 0,0,0,0);
      // limit 0 one-shot
      step(1,1,0,0,0); e4("l0_start", 0,1,0,0);
      step(1,0,0,0,0); e4("l0_prime", 0,1,0,0);
      step(1,0,0,0,0); e4("l0_done", 0,0,1,0);
      step(1,0,0,0,0); e4("l0_idle", 0,0,0,0);
      // stop exactly at count==limit
      step(1,1,0,0,2); e4("sl_start", 0,1,0,0);
      for (int k = 0; k <= 2; k++) begin step(1,0,0,0,0); e4("sl_run", k,1,0,0); end
      step(1,0,1,0,0); e4("sl_stop", 2,1,0,0);
      step(1,0,0,0,0); e4("sl_hold", 2,1,0,0);
      step(1,1,0,0,0); e4("sl_resume", 2,1,0,0);
      step(1,0,0,0,0); e4("sl_done", 2,0,1,0);
      step(1,0,0,0,0); e4("sl_idle", 2,0,0,0);
      // reset mid-run in auto-reload
      step(1,1,0,1,2); e4("rm_start", 0,1,0,0);
      step(1,0,0,0,0); e4("rm_p", 0,1,0,0);
      step(1,0,0,0,0); e4("rm_1", 1,1,0,0);
      step(1,0,0,0,0); e4("rm_2", 2,1,0,0);
      step(1,0,0,0,0); e4("rm_wrap", 0,1,1,1);
      step(1,0,0,0,0); e4("rm_1b", 1,1,0,1);
      step(1,0,0,0,0); e4("rm_2b", 2,1,0,1);
      step(0,0,0,0,0); e4("rm_reset", 0,0,0,0);
      step(1,0,0,0,0); e4("rm_after", 0,0,0,0);

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         bit r, s, p, m;
         int l;
         r = ($urandom_range(0, 149) != 0);
         s = ($urandom_range(0, 2) == 0);
         p = ($urandom_range(0, 9) == 0);
         m = ($urandom_range(0, 1) == 1);
         l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
         step(r, s, p, m, l);
         e4($sformatf("rnd%0d", i), m_cnt, m_act, m_done, m_tally);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
